bdu_result_arbiter: RTL and testbench
=====================================

// Module: bdu_result_arbiter
// PURPOSE
//  Collects finished distance results from the NUM_BDU bit-serial distance units and
//  serialises them into the TopK insertion port, one entry per cycle.
//  It sits between the BDU array and TopK and drives TopK's valid/point_in pair.
//  It counts issued points per query and flags query completion.
// PARAMETERS
//  NUM_BDU     `NUM_BDU (4)     number of BDU result ports / width of one-hot grant
//  DIST_WIDTH  `DIST_WIDTH      distance field width inside knn_entry_t
//  CNT_WIDTH   16               width of per-query point counter
// PORTS
//  clk           in   1                   single clock, rising edge
//  reset         in   1                   async, active-low (0 = reset)
//  query_start   in   1                   pulse: begin new query, clears all state
//  num_points    in   CNT_WIDTH           points expected this query, sampled on query_start
//  bdu_done      in   NUM_BDU             per-BDU result-valid pulse
//  bdu_entry     in   knn_entry_t[NUM_BDU] per-BDU result {distance, valid}
//  bdu_ready     out  NUM_BDU             per-BDU holding slot empty
//  topk_valid    out  NUM_BDU             one-hot grant to TopK.valid, 1 cycle per entry
//  topk_entry    out  knn_entry_t         entry to TopK.point_in
//  issued_count  out  CNT_WIDTH           entries issued this query
//  query_done    out  1                   high in DONE state
//  overflow      out  1                   sticky: a result was dropped
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, all slots empty, rr_ptr=0, topk_valid=0,
//   topk_entry=0, issued_count=0, query_done=0, overflow=0, bdu_ready=all 1.
//  FSM: IDLE --query_start--> RUN; RUN --last issue--> DONE; DONE --query_start--> RUN.
//   query_start in any state (including RUN): clear slots, count, rr_ptr, overflow;
//   latch num_points. If num_points==0, go to DONE on the next edge.
//  Capture: in RUN, bdu_done[i] && slot i empty -> slot i <= bdu_entry[i] at that edge.
//   bdu_done[i] with slot i full, or any bdu_done outside RUN -> entry dropped, overflow<=1.
//  bdu_ready[i] = ~slot_full[i] (registered state only; no same-cycle refill of a slot
//   being issued).
//  Issue: in RUN, each edge picks the first full slot scanning rr_ptr, rr_ptr+1, ... mod
//   NUM_BDU. Then topk_valid <= onehot(i), topk_entry <= slot i, slot i freed,
//   rr_ptr <= (i+1) mod NUM_BDU, issued_count++. No full slot -> topk_valid <= 0.
//  Latency: bdu_done sampled at edge t -> earliest topk_valid high in the cycle after
//   edge t+1. Throughput: 1 entry/cycle. topk_valid is never multi-hot.
//  Entry fields pass through unmodified: distance and valid bits are copied bit-exact.
//  Completion: the edge that makes issued_count == num_points also sets state=DONE.
//   query_done=1 from then on. No further issues, and topk_valid=0 after that pulse.
//   issued_count holds its value.
//  Simultaneous capture and issue on different slots in one cycle are both performed.
// STRUCTURE
//  knn_entry_t, `NUM_BDU, `DIST_WIDTH, `K stay in global_defs.sv.
//  Add arb_state_t enum {IDLE, RUN, DONE} to global_defs.sv.
//  One sub-module: rr_arbiter (NUM_BDU req -> one-hot grant plus next pointer,
//   combinational).
// TESTING
//  1 Reset low mid-RUN with 2 slots full -> all outputs reach reset values immediately,
//    bdu_ready=4'b1111.
//  2 query_start num_points=3; bdu_done=4'b0100, dist=60 -> next cycle
//    topk_valid=4'b0100, topk_entry.distance=60, issued_count=1.
//  3 bdu_done=4'b1111 with dists 10,20,30,40 and rr_ptr=2 -> issue order 30,40,10,20 on
//    4 consecutive cycles; topk_valid is one-hot every cycle.
//  4 num_points=2, three results arrive -> query_done=1 after the 2nd issue; the 3rd
//    entry is never issued; issued_count stays 2.
//  5 bdu_done[0] twice on consecutive cycles while slot 0 is still full -> 2nd dropped,
//    overflow=1, only the first entry is issued.
//  6 query_start with num_points=0 -> query_done=1 on the next cycle, topk_valid stays 0.

Source files
------------

// File: rtl/bdu_result_arbiter_pkg.sv
// rtl/bdu_result_arbiter_pkg.sv - shared types for the BDU result arbiter
package bdu_result_arbiter_pkg;

   localparam int NUM_BDU    = 4;
   localparam int DIST_WIDTH = 16;
   localparam int PTR_W      = (NUM_BDU > 1) ? $clog2(NUM_BDU) : 1;

   typedef struct packed {
      logic [DIST_WIDTH-1:0] distance;
      logic                  valid;
   } knn_entry_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} arb_state_t;

endpackage

// File: rtl/bdu_result_arbiter_rr_arbiter.sv
// rtl/bdu_result_arbiter_rr_arbiter.sv - combinational round-robin picker
// Grants the first request found scanning from ptr_i upward, wrapping modulo N.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic             any_o,
   output logic [PTR_W-1:0] idx_o,
   output logic [PTR_W-1:0] next_ptr_o
);

   logic [PTR_W-1:0] cand;

   always_comb begin
      grant_o    = '0;
      any_o      = 1'b0;
      idx_o      = '0;
      next_ptr_o = ptr_i;
      cand       = '0;
      for (int k = 0; k < N; k++) begin
         cand = PTR_W'((int'(ptr_i) + k) % N);
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o       = cand;
            next_ptr_o  = PTR_W'((int'(cand) + 1) % N);
         end
      end
   end

endmodule

// File: rtl/bdu_result_arbiter.sv
// rtl/bdu_result_arbiter.sv - serialises BDU distance results into the TopK insert port
// One holding slot per BDU; a round-robin scan drains at most one slot per cycle.
module bdu_result_arbiter
   import bdu_result_arbiter_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         query_start,
   input  logic [CNT_WIDTH-1:0]         num_points,
   input  logic [NUM_BDU-1:0]           bdu_done,
   input  knn_entry_t [NUM_BDU-1:0]     bdu_entry,
   output logic [NUM_BDU-1:0]           bdu_ready,
   output logic [NUM_BDU-1:0]           topk_valid,
   output knn_entry_t                   topk_entry,
   output logic [CNT_WIDTH-1:0]         issued_count,
   output logic                         query_done,
   output logic                         overflow
);

   arb_state_t                state_q;
   knn_entry_t [NUM_BDU-1:0]  slot_q;
   logic [NUM_BDU-1:0]        full_q;
   logic [PTR_W-1:0]          rr_ptr_q;
   logic [CNT_WIDTH-1:0]      count_q;
   logic [CNT_WIDTH-1:0]      target_q;
   logic [NUM_BDU-1:0]        topk_valid_q;
   knn_entry_t                topk_entry_q;
   logic                      done_q;
   logic                      overflow_q;

   logic [NUM_BDU-1:0]        grant;
   logic                      grant_any;
   logic [PTR_W-1:0]          grant_idx;
   logic [PTR_W-1:0]          next_ptr;
   logic [CNT_WIDTH-1:0]      count_inc;

   assign count_inc = count_q + 1'b1;

   rr_arbiter #(
      .N     (NUM_BDU),
      .PTR_W (PTR_W)
   ) u_rr (
      .req_i      (full_q),
      .ptr_i      (rr_ptr_q),
      .grant_o    (grant),
      .any_o      (grant_any),
      .idx_o      (grant_idx),
      .next_ptr_o (next_ptr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         slot_q       <= '0;
         full_q       <= '0;
         rr_ptr_q     <= '0;
         count_q      <= '0;
         target_q     <= '0;
         topk_valid_q <= '0;
         topk_entry_q <= '0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else if (query_start) begin
         // Results arriving on the start edge belong to no query and are ignored.
         state_q      <= (num_points == '0) ? DONE : RUN;
         full_q       <= '0;
         rr_ptr_q     <= '0;
         count_q      <= '0;
         target_q     <= num_points;
         topk_valid_q <= '0;
         done_q       <= (num_points == '0);
         overflow_q   <= 1'b0;
      end else begin
         topk_valid_q <= '0;
         if (state_q == RUN) begin
            for (int i = 0; i < NUM_BDU; i++) begin
               if (bdu_done[i]) begin
                  if (full_q[i]) overflow_q <= 1'b1;
                  else           slot_q[i]  <= bdu_entry[i];
               end
            end
            // Capture looks only at registered fullness, so a slot issued now cannot refill.
            full_q <= (full_q & ~grant) | (bdu_done & ~full_q);
            if (grant_any) begin
               topk_valid_q <= grant;
               topk_entry_q <= slot_q[grant_idx];
               rr_ptr_q     <= next_ptr;
               count_q      <= count_inc;
               if (count_inc == target_q) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
         end else if (|bdu_done) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign bdu_ready    = ~full_q;
   assign topk_valid   = topk_valid_q;
   assign topk_entry   = topk_entry_q;
   assign issued_count = count_q;
   assign query_done   = done_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_bdu_result_arbiter.sv
// tb/tb_bdu_result_arbiter.sv - directed self-checking bench for bdu_result_arbiter
module tb_bdu_result_arbiter;
   import bdu_result_arbiter_pkg::*;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     query_start;
   logic [15:0]              num_points;
   logic [NUM_BDU-1:0]       bdu_done;
   knn_entry_t [NUM_BDU-1:0] bdu_entry;
   logic [NUM_BDU-1:0]       bdu_ready;
   logic [NUM_BDU-1:0]       topk_valid;
   knn_entry_t               topk_entry;
   logic [15:0]              issued_count;
   logic                     query_done;
   logic                     overflow;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bdu_result_arbiter #(.CNT_WIDTH(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .query_start  (query_start),
      .num_points   (num_points),
      .bdu_done     (bdu_done),
      .bdu_entry    (bdu_entry),
      .bdu_ready    (bdu_ready),
      .topk_valid   (topk_valid),
      .topk_entry   (topk_entry),
      .issued_count (issued_count),
      .query_done   (query_done),
      .overflow     (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_entry(input int i, input int d);
      bdu_entry[i].distance = DIST_WIDTH'(d);
      bdu_entry[i].valid    = 1'b1;
   endtask

   task automatic start(input int np);
      query_start = 1'b1;
      num_points  = 16'(np);
      tick();
      query_start = 1'b0;
   endtask

   int exp_dist [4];
   logic [3:0] exp_grant [4];

   initial begin
      reset       = 1'b0;
      query_start = 1'b0;
      num_points  = '0;
      bdu_done    = '0;
      bdu_entry   = '0;
      tick();
      tick();
      chk("rst_valid", 32'(topk_valid), 0);
      chk("rst_entry", 32'(topk_entry), 0);
      chk("rst_count", 32'(issued_count), 0);
      chk("rst_done", 32'(query_done), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_ready", 32'(bdu_ready), 32'hf);
      reset = 1'b1;
      tick();

      // single result, two-edge latency
      start(3);
      chk("t2_done0", 32'(query_done), 0);
      chk("t2_cnt0", 32'(issued_count), 0);
      bdu_done = 4'b0100;
      set_entry(2, 60);
      tick();
      bdu_done = '0;
      chk("t2_ready_cap", 32'(bdu_ready), 32'hb);
      chk("t2_valid_cap", 32'(topk_valid), 0);
      tick();
      chk("t2_valid", 32'(topk_valid), 32'h4);
      chk("t2_dist", 32'(topk_entry.distance), 60);
      chk("t2_vbit", 32'(topk_entry.valid), 1);
      chk("t2_cnt", 32'(issued_count), 1);
      chk("t2_ready", 32'(bdu_ready), 32'hf);
      tick();
      chk("t2_valid_off", 32'(topk_valid), 0);

      // asynchronous reset mid-run with two slots still full
      start(5);
      bdu_done = 4'b0111;
      set_entry(0, 1);
      set_entry(1, 2);
      set_entry(2, 3);
      tick();
      bdu_done = '0;
      tick();
      chk("t1_pre_valid", 32'(topk_valid), 32'h1);
      chk("t1_pre_ready", 32'(bdu_ready), 32'h9);
      #2 reset = 1'b0;
      #1;
      chk("t1_valid", 32'(topk_valid), 0);
      chk("t1_entry", 32'(topk_entry), 0);
      chk("t1_count", 32'(issued_count), 0);
      chk("t1_done", 32'(query_done), 0);
      chk("t1_ready", 32'(bdu_ready), 32'hf);
      reset = 1'b1;
      tick();

      // round-robin order starting from rr_ptr=2
      start(10);
      bdu_done = 4'b0010;
      set_entry(1, 5);
      tick();
      bdu_done = '0;
      tick();
      chk("t3_pre_valid", 32'(topk_valid), 32'h2);
      bdu_done = 4'b1111;
      set_entry(0, 10);
      set_entry(1, 20);
      set_entry(2, 30);
      set_entry(3, 40);
      tick();
      bdu_done = '0;
      chk("t3_ready_full", 32'(bdu_ready), 0);
      exp_dist  = '{30, 40, 10, 20};
      exp_grant = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("t3_valid%0d", k), 32'(topk_valid), 32'(exp_grant[k]));
         chk($sformatf("t3_dist%0d", k), 32'(topk_entry.distance), 32'(exp_dist[k]));
      end
      chk("t3_cnt", 32'(issued_count), 5);

      // completion stops issuing, leftover entry stays parked
      start(2);
      bdu_done = 4'b0111;
      set_entry(0, 7);
      set_entry(1, 8);
      set_entry(2, 9);
      tick();
      bdu_done = '0;
      tick();
      chk("t4_dist0", 32'(topk_entry.distance), 7);
      chk("t4_done0", 32'(query_done), 0);
      tick();
      chk("t4_valid1", 32'(topk_valid), 32'h2);
      chk("t4_dist1", 32'(topk_entry.distance), 8);
      chk("t4_done1", 32'(query_done), 1);
      chk("t4_cnt1", 32'(issued_count), 2);
      tick();
      chk("t4_valid_off", 32'(topk_valid), 0);
      chk("t4_cnt_hold", 32'(issued_count), 2);
      chk("t4_ready", 32'(bdu_ready), 32'hb);
      chk("t4_ovf0", 32'(overflow), 0);
      bdu_done = 4'b0001;
      tick();
      bdu_done = '0;
      chk("t4_ovf_done", 32'(overflow), 1);
      chk("t4_valid_done", 32'(topk_valid), 0);

      // back-to-back result on an occupied slot is dropped
      start(4);
      chk("t5_ovf_clr", 32'(overflow), 0);
      chk("t5_done_clr", 32'(query_done), 0);
      bdu_done = 4'b0001;
      set_entry(0, 11);
      tick();
      set_entry(0, 12);
      tick();
      bdu_done = '0;
      chk("t5_valid", 32'(topk_valid), 32'h1);
      chk("t5_dist", 32'(topk_entry.distance), 11);
      chk("t5_ovf", 32'(overflow), 1);
      tick();
      chk("t5_valid_off", 32'(topk_valid), 0);
      chk("t5_cnt", 32'(issued_count), 1);
      chk("t5_ready", 32'(bdu_ready), 32'hf);

      // zero-point query completes immediately
      start(0);
      chk("t6_done", 32'(query_done), 1);
      chk("t6_valid", 32'(topk_valid), 0);
      tick();
      chk("t6_valid2", 32'(topk_valid), 0);
      chk("t6_cnt", 32'(issued_count), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
